plab3_mem_prefetch_scheduler: RTL
=================================

# plab3_mem_prefetch_scheduler

Sequences the single-ported prefetch buffer and shares it between two requesters: processor-side demand reads and an internal next-line prefetch generator. Demand reads are forwarded as READ requests. Buffer misses, which the buffer signals by returning to idle without a response, are converted into explicit miss responses. After every demand read, a PRELW for the following 16-byte line is queued and issued when the buffer is otherwise unused. Sits between the L1 miss path and the prefetch buffer; one transaction in flight at a time.

## Interface
Parameters:
- p_opaque_nbits, 8, opaque field width (o)
- p_cnt_nbits, 16, width of statistics counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; same reset drives the prefetch buffer
- dmreq_val / dmreq_rdy  in / out  1 / 1  demand request handshake
- dmreq_addr  in  32  demand byte address
- dmreq_opaque  in  o  demand tag, returned on the response
- dmresp_val / dmresp_rdy  out / in  1 / 1  demand response handshake
- dmresp_hit  out  1  1 = data valid from buffer; 0 = miss, requester goes to memory
- dmresp_data  out  32  read data (0 when dmresp_hit=0)
- dmresp_opaque  out  o  echoed dmreq_opaque
- bufreq_val / bufreq_rdy  out / in  1 / 1  request to buffer
- bufreq_type  out  3  `VC_MEM_REQ_MSG_TYPE_READ or `VC_MEM_REQ_MSG_TYPE_PRELW
- bufreq_addr  out  32  request address
- bufresp_val / bufresp_rdy  in / out  1 / 1  buffer response
- bufresp_data  in  32  buffer read data
- pf_issued_cnt  out  p_cnt_nbits  count of PRELW requests accepted by the buffer
- pf_dropped_cnt  out  p_cnt_nbits  count of pending prefetches overwritten before issue

## Operation
- States: IDLE, DREQ, DWAIT, DRESP, PREQ, PWAIT.
- IDLE: dmreq_rdy=1. If dmreq_val: capture addr and opaque, go to DREQ. Otherwise, if a prefetch is pending, go to PREQ. Demand always wins over a pending prefetch.
- DREQ: bufreq_val=1, type READ, captured addr. Go to DWAIT on bufreq_rdy.
- DWAIT: bufresp_rdy=1.
  - bufresp_val: capture data, hit=1, go to DRESP.
  - Otherwise, bufreq_rdy=1 in any cycle except the first DWAIT cycle: miss. Set hit=0, data=0, go to DRESP.
- DRESP: dmresp_val=1, held stable until dmresp_rdy. Then run candidate generation and go to IDLE.
- Candidate generation (every demand completion, hit or miss):
  - next = captured addr[31:4] + 1, modulo 2^28, so line 0xFFFFFFF wraps to 0.
  - If last_pf is valid and next == last_pf, suppress the candidate.
  - Otherwise write next into the single pending slot. If the slot was already valid, increment pf_dropped_cnt.
- PREQ: bufreq_val=1, type PRELW, addr = {pending_line, 4'b0}. On bufreq_rdy: clear pending, set last_pf=pending_line and valid, increment pf_issued_cnt, go to PWAIT.
- PWAIT: bufresp_rdy=1. The response is discarded. Go to IDLE on bufresp_val, or on bufreq_rdy after the first PWAIT cycle (buffer already held the line). dmreq_rdy=0 throughout; an in-flight prefetch is never preempted.
- Counters wrap modulo 2^p_cnt_nbits.
- Simultaneous events:
  - A candidate written in the DRESP completion cycle while a pending slot exists overwrites it; the old entry is dropped.
  - bufresp_val and bufreq_rdy together in DWAIT: treat as a hit.
- Non-READ demand types are not accepted; the requester issues only reads, and an assertion on the type-checking wrapper enforces this.

## Timing
- Reset values: state=IDLE, pending invalid, last_pf invalid, both counters 0.
- Output values after reset: dmreq_rdy=1, dmresp_val=0, bufreq_val=0, bufresp_rdy=0, dmresp_hit=0, dmresp_data=0.
- Reset asserted mid-operation: immediate return to IDLE. Pending, last_pf and counters are cleared, and any demand in flight is lost.
- All outputs are decoded from registered state and captured registers; there is no combinational path from a *_val input to a *_rdy output.
- Demand-hit latency, with the buffer idle and all ready signals high: accept T, DREQ T+1, buffer TAG_CHECK T+2, buffer data access T+3, bufresp T+4, dmresp_val T+5.
- Demand-miss latency: the buffer is idle again at T+3 and dmresp_val rises at T+4.
- A prefetch issues no earlier than the cycle after DRESP completes, and only if dmreq_val=0 in that IDLE cycle.

## Structure
- Shared package/header holds the state encodings (3-bit) and the line-offset constant (4). Type codes come from vc-mem-msgs.v.
- One sub-module: plab3_mem_prefetch_next_line_gen, holding the pending slot, last_pf register, suppression compare and both counters. The FSM stays in the top module.

## Test plan
- Buffer holds line 0x100. Read 0x104 with opaque 0x3A -> dmresp hit=1, buffer data, opaque 0x3A, at T+5. Then PRELW addr 0x110 is issued and pf_issued_cnt=1.
- Empty buffer, read 0x2000 -> dmresp hit=0, data 0, at T+4. Then PRELW 0x2010 is issued.
- Two consecutive reads to 0x2000, with the first prefetch completed before the second read -> the second candidate is suppressed; pf_issued_cnt stays 1.
- Back-to-back demands to 0x0, 0x40, 0x80 with dmreq_val held high -> no PRELW issued until dmreq_val drops. pf_dropped_cnt=2; the PRELW finally issued is 0x90.
- Read 0xFFFFFFF8 -> PRELW addr 0x00000000.
- Assert reset during PWAIT -> next cycle state=IDLE, counters 0, bufreq_val=0, dmreq_rdy=1.

Source files
------------

// File: rtl/plab3_mem_prefetch_scheduler_pkg.sv
// Shared encodings for the prefetch scheduler: FSM states, line geometry, buffer request types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package plab3_mem_prefetch_scheduler_pkg;

    // Scheduler FSM states, 3-bit encoded
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DREQ  = 3'd1,
        ST_DWAIT = 3'd2,
        ST_DRESP = 3'd3,
        ST_PREQ  = 3'd4,
        ST_PWAIT = 3'd5
    } state_t;

    // 16-byte lines: 4 offset bits, 28-bit line number
    localparam int unsigned c_line_offset_nbits = 4;
    localparam int unsigned c_line_nbits        = 32 - c_line_offset_nbits;

    // Buffer request type codes, matching vc-mem-msgs.v
    localparam logic [2:0] c_mem_req_type_read  = 3'd0;
    localparam logic [2:0] c_mem_req_type_prelw = 3'd2;

    // Line following the one holding addr; wraps at the top of the address space
    function automatic logic [c_line_nbits-1:0] next_line(input logic [c_line_nbits-1:0] line);
        return line + {{(c_line_nbits-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/plab3_mem_prefetch_next_line_gen.sv
// Next-line prefetch bookkeeping: single pending slot, last-issued line, suppression, statistics.
// Latency: candidate visible on pend_val the cycle after cand_val.
// Backpressure: none; a new candidate overwrites an unissued one and counts it as dropped.
module plab3_mem_prefetch_next_line_gen
    import plab3_mem_prefetch_scheduler_pkg::*;
#(
    parameter int p_cnt_nbits = 16
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cand_val,
    input  logic [c_line_nbits-1:0] cand_line,
    input  logic                    issue,
    output logic                    pend_val,
    output logic [c_line_nbits-1:0] pend_line,
    output logic [p_cnt_nbits-1:0]  pf_issued_cnt,
    output logic [p_cnt_nbits-1:0]  pf_dropped_cnt
);

    localparam logic [p_cnt_nbits-1:0] c_cnt_one = {{(p_cnt_nbits-1){1'b0}}, 1'b1};

    logic                    last_pf_val;
    logic [c_line_nbits-1:0] last_pf_line;
    logic                    suppress;
    logic                    cand_write;

    // A candidate equal to the line just prefetched would be wasted buffer bandwidth
    assign suppress   = last_pf_val && (cand_line == last_pf_line);
    assign cand_write = cand_val && !suppress;

    // Pending slot, last prefetched line and counters; candidate and issue never coincide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_val       <= 1'b0;
            pend_line      <= '0;
            last_pf_val    <= 1'b0;
            last_pf_line   <= '0;
            pf_issued_cnt  <= '0;
            pf_dropped_cnt <= '0;
        end else if (cand_write) begin
            pend_val  <= 1'b1;
            pend_line <= cand_line;
            if (pend_val)
                pf_dropped_cnt <= pf_dropped_cnt + c_cnt_one;
        end else if (issue) begin
            pend_val      <= 1'b0;
            last_pf_val   <= 1'b1;
            last_pf_line  <= pend_line;
            pf_issued_cnt <= pf_issued_cnt + c_cnt_one;
        end
    end

endmodule

// File: rtl/plab3_mem_prefetch_scheduler.sv
// Shares the prefetch buffer between demand reads and next-line PRELW prefetches, one transaction at a time.
// Latency: demand hit dmresp_val at T+5, miss at T+4 after acceptance at T; prefetch only when idle.
// Backpressure: dmreq_rdy only in IDLE; dmresp held until dmresp_rdy; buffer handshakes wait on bufreq_rdy/bufresp_val.
module plab3_mem_prefetch_scheduler
    import plab3_mem_prefetch_scheduler_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int p_cnt_nbits    = 16
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dmreq_val,
    output logic                      dmreq_rdy,
    input  logic [31:0]               dmreq_addr,
    input  logic [p_opaque_nbits-1:0] dmreq_opaque,
    output logic                      dmresp_val,
    input  logic                      dmresp_rdy,
    output logic                      dmresp_hit,
    output logic [31:0]               dmresp_data,
    output logic [p_opaque_nbits-1:0] dmresp_opaque,
    output logic                      bufreq_val,
    input  logic                      bufreq_rdy,
    output logic [2:0]                bufreq_type,
    output logic [31:0]               bufreq_addr,
    input  logic                      bufresp_val,
    output logic                      bufresp_rdy,
    input  logic [31:0]               bufresp_data,
    output logic [p_cnt_nbits-1:0]    pf_issued_cnt,
    output logic [p_cnt_nbits-1:0]    pf_dropped_cnt
);

    state_t                    state;
    state_t                    state_next;
    logic [31:0]               dm_addr;
    logic [p_opaque_nbits-1:0] dm_opaque;
    logic                      resp_hit;
    logic [31:0]               resp_data;
    logic                      wait_first;
    logic                      dwait_hit;
    logic                      dwait_miss;
    logic                      cand_val;
    logic                      pf_issue;
    logic                      pend_val;
    logic [c_line_nbits-1:0]   pend_line;

    // The buffer returning to idle without a response means a miss; never trust rdy in the first wait cycle
    assign dwait_hit  = (state == ST_DWAIT) && bufresp_val;
    assign dwait_miss = (state == ST_DWAIT) && !bufresp_val && bufreq_rdy && !wait_first;

    // Next-state and output decode from registered state only
    always_comb begin
        state_next  = state;
        dmreq_rdy   = 1'b0;
        dmresp_val  = 1'b0;
        bufreq_val  = 1'b0;
        bufreq_type = c_mem_req_type_read;
        bufreq_addr = '0;
        bufresp_rdy = 1'b0;
        cand_val    = 1'b0;
        pf_issue    = 1'b0;
        case (state)
            ST_IDLE: begin
                dmreq_rdy = 1'b1;
                if (dmreq_val)
                    state_next = ST_DREQ;
                else if (pend_val)
                    state_next = ST_PREQ;
            end
            ST_DREQ: begin
                bufreq_val  = 1'b1;
                bufreq_addr = dm_addr;
                if (bufreq_rdy)
                    state_next = ST_DWAIT;
            end
            ST_DWAIT: begin
                bufresp_rdy = 1'b1;
                if (dwait_hit || dwait_miss)
                    state_next = ST_DRESP;
            end
            ST_DRESP: begin
                dmresp_val = 1'b1;
                if (dmresp_rdy) begin
                    cand_val   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_PREQ: begin
                bufreq_val  = 1'b1;
                bufreq_type = c_mem_req_type_prelw;
                bufreq_addr = {pend_line, {c_line_offset_nbits{1'b0}}};
                if (bufreq_rdy) begin
                    pf_issue   = 1'b1;
                    state_next = ST_PWAIT;
                end
            end
            ST_PWAIT: begin
                bufresp_rdy = 1'b1;
                if (bufresp_val || (bufreq_rdy && !wait_first))
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus the first-cycle marker for the two buffer wait states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_first <= 1'b0;
        end else begin
            state      <= state_next;
            wait_first <= (state_next != state) &&
                          ((state_next == ST_DWAIT) || (state_next == ST_PWAIT));
        end
    end

    // Demand capture on acceptance and response capture on hit or detected miss
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm_addr   <= '0;
            dm_opaque <= '0;
            resp_hit  <= 1'b0;
            resp_data <= '0;
        end else begin
            if ((state == ST_IDLE) && dmreq_val) begin
                dm_addr   <= dmreq_addr;
                dm_opaque <= dmreq_opaque;
            end
            if (dwait_hit) begin
                resp_hit  <= 1'b1;
                resp_data <= bufresp_data;
            end else if (dwait_miss) begin
                resp_hit  <= 1'b0;
                resp_data <= '0;
            end
        end
    end

    assign dmresp_hit    = resp_hit;
    assign dmresp_data   = resp_data;
    assign dmresp_opaque = dm_opaque;

    plab3_mem_prefetch_next_line_gen #(
        .p_cnt_nbits (p_cnt_nbits)
    ) u_next_line_gen (
        .clk            (clk),
        .reset          (reset),
        .cand_val       (cand_val),
        .cand_line      (next_line(dm_addr[31:c_line_offset_nbits])),
        .issue          (pf_issue),
        .pend_val       (pend_val),
        .pend_line      (pend_line),
        .pf_issued_cnt  (pf_issued_cnt),
        .pf_dropped_cnt (pf_dropped_cnt)
    );

endmodule
